// File: rtl/bus_arb.sv
// Two-master bus arbiter: instruction fetch (m0) and load/store (m1) share one bus master port.
// Round-robin or fixed-priority arbitration, m1 bus lock for atomics, one-cycle read return routing.
module bus_arb #(
  parameter bit RR = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [1:0]  m0_size_i,
  input  logic        m0_rd_i,
  input  logic        m0_wr_i,
  output logic        m0_ready_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_rvalid_o,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [1:0]  m1_size_i,
  input  logic        m1_rd_i,
  input  logic        m1_wr_i,
  output logic        m1_ready_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_rvalid_o,
  input  logic        m1_lock_i,
  output logic [31:0] b_addr_o,
  output logic [31:0] b_wdata_o,
  output logic [1:0]  b_size_o,
  output logic        b_rd_o,
  output logic        b_wr_o,
  input  logic [31:0] b_rdata_i
);

  logic req0, req1, gnt0, gnt1;
  logic last_q, last_d;
  logic lock_q, lock_d;
  logic pend_q, pend_d;
  logic own_q, own_d;

  assign req0 = m0_rd_i | m0_wr_i;
  assign req1 = m1_rd_i | m1_wr_i;

  // Winner selection; grants are forced low while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n_i) begin
      if (lock_q) begin
        gnt1 = req1;
      end else if (req0 && req1) begin
        if (RR && !last_q) gnt1 = 1'b1;
        else               gnt0 = 1'b1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Bus mux; rd together with wr is forwarded as a plain write.
  always_comb begin
    b_addr_o  = 32'd0;
    b_wdata_o = 32'd0;
    b_size_o  = 2'd0;
    b_rd_o    = 1'b0;
    b_wr_o    = 1'b0;
    if (gnt0) begin
      b_addr_o  = m0_addr_i;
      b_wdata_o = m0_wdata_i;
      b_size_o  = m0_size_i;
      b_rd_o    = m0_rd_i & ~m0_wr_i;
      b_wr_o    = m0_wr_i;
    end else if (gnt1) begin
      b_addr_o  = m1_addr_i;
      b_wdata_o = m1_wdata_i;
      b_size_o  = m1_size_i;
      b_rd_o    = m1_rd_i & ~m1_wr_i;
      b_wr_o    = m1_wr_i;
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt0) last_d = 1'b0;
    if (gnt1) last_d = 1'b1;

    lock_d = lock_q;
    if (gnt1 && m1_lock_i) lock_d = 1'b1;
    else if (!m1_lock_i)   lock_d = 1'b0;

    pend_d = b_rd_o;
    own_d  = b_rd_o ? gnt1 : own_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_q <= 1'b1;
      lock_q <= 1'b0;
      pend_q <= 1'b0;
      own_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      lock_q <= lock_d;
      pend_q <= pend_d;
      own_q  <= own_d;
    end
  end

  assign m0_ready_o  = gnt0;
  assign m1_ready_o  = gnt1;
  assign m0_rvalid_o = pend_q & ~own_q;
  assign m1_rvalid_o = pend_q & own_q;
  assign m0_rdata_o  = b_rdata_i;
  assign m1_rdata_o  = b_rdata_i;

endmodule

// File: tb/tb_bus_arb.sv
// Bench for bus_arb: directed scenarios plus randomized traffic against a cycle-stamped
// reference model of grants, lock ownership and read-return routing.
module tb_bus_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, b_rdata;
  logic [1:0]  m0_size, m1_size;
  logic        m0_rd, m0_wr, m1_rd, m1_wr, m1_lock;
  logic        m0_ready, m1_ready, m0_rvalid, m1_rvalid, b_rd, b_wr;
  logic [31:0] m0_rdata, m1_rdata, b_addr, b_wdata;
  logic [1:0]  b_size;
  logic        fp_m0_ready, fp_m1_ready, fp_m0_rvalid, fp_m1_rvalid, fp_b_rd, fp_b_wr;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_b_addr, fp_b_wdata;
  logic [1:0]  fp_b_size;

  int checks = 0;
  int errors = 0;
  int mlast, mcyc;
  bit mlock;
  int pq_cyc[$];
  int pq_own[$];

  always #5 clk = ~clk;

  bus_arb #(.RR(1'b1)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_size_i(m0_size), .m0_rd_i(m0_rd), .m0_wr_i(m0_wr),
    .m0_ready_o(m0_ready), .m0_rdata_o(m0_rdata), .m0_rvalid_o(m0_rvalid),
    .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_size_i(m1_size), .m1_rd_i(m1_rd), .m1_wr_i(m1_wr),
    .m1_ready_o(m1_ready), .m1_rdata_o(m1_rdata), .m1_rvalid_o(m1_rvalid), .m1_lock_i(m1_lock),
    .b_addr_o(b_addr), .b_wdata_o(b_wdata), .b_size_o(b_size), .b_rd_o(b_rd), .b_wr_o(b_wr),
    .b_rdata_i(b_rdata));

  bus_arb #(.RR(1'b0)) dut_fp (
    .clk_i(clk), .reset_n_i(rst_n),
    .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_size_i(m0_size), .m0_rd_i(m0_rd), .m0_wr_i(m0_wr),
    .m0_ready_o(fp_m0_ready), .m0_rdata_o(fp_m0_rdata), .m0_rvalid_o(fp_m0_rvalid),
    .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_size_i(m1_size), .m1_rd_i(m1_rd), .m1_wr_i(m1_wr),
    .m1_ready_o(fp_m1_ready), .m1_rdata_o(fp_m1_rdata), .m1_rvalid_o(fp_m1_rvalid), .m1_lock_i(m1_lock),
    .b_addr_o(fp_b_addr), .b_wdata_o(fp_b_wdata), .b_size_o(fp_b_size), .b_rd_o(fp_b_rd), .b_wr_o(fp_b_wr),
    .b_rdata_i(b_rdata));

  // Reference model (round-robin instance): -1 means nobody wins.
  function automatic int exp_win();
    bit r0, r1;
    r0 = m0_rd | m0_wr;
    r1 = m1_rd | m1_wr;
    if (mlock) return r1 ? 1 : -1;
    if (r0 && r1) return 1 - mlast;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic bit exp_rvalid(input int x);
    return pq_cyc.size() > 0 && pq_cyc[0] == mcyc && pq_own[0] == x;
  endfunction

  task automatic model_reset();
    mlast = 1;
    mlock = 1'b0;
    pq_cyc.delete();
    pq_own.delete();
  endtask

  // Advance the model over one rising edge, then move to the next falling edge.
  task automatic tick();
    int w;
    bit rd;
    w = exp_win();
    if (w >= 0) begin
      rd = (w == 1) ? (m1_rd && !m1_wr) : (m0_rd && !m0_wr);
      if (rd) begin
        pq_cyc.push_back(mcyc + 1);
        pq_own.push_back(w);
      end
      mlast = w;
    end
    if (w == 1 && m1_lock) mlock = 1'b1;
    else if (!m1_lock)     mlock = 1'b0;
    @(negedge clk);
    mcyc++;
    while (pq_cyc.size() > 0 && pq_cyc[0] < mcyc) begin
      void'(pq_cyc.pop_front());
      void'(pq_own.pop_front());
    end
  endtask

  task automatic clear_reqs();
    m0_addr = 0; m0_wdata = 0; m0_size = 0; m0_rd = 0; m0_wr = 0;
    m1_addr = 0; m1_wdata = 0; m1_size = 0; m1_rd = 0; m1_wr = 0;
    m1_lock = 0;
  endtask

  task automatic do_reset();
    clear_reqs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    m0_rd = 1; m1_wr = 1; m1_lock = 1; rst_n = 1'b0;
    #1;
    checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL reset_m0_ready got %0b exp 0", m0_ready); end
    checks++; if (m1_ready !== 1'b0) begin errors++; $display("FAIL reset_m1_ready got %0b exp 0", m1_ready); end
    checks++; if (b_rd !== 1'b0 || b_wr !== 1'b0) begin errors++; $display("FAIL reset_b_strobes got rd=%0b wr=%0b exp 0", b_rd, b_wr); end
    checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %0b%0b exp 00", m0_rvalid, m1_rvalid); end
    clear_reqs();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_idle();
    clear_reqs();
    #1;
    checks++; if (b_rd !== 1'b0 || b_wr !== 1'b0) begin errors++; $display("FAIL idle_strobes got rd=%0b wr=%0b exp 0", b_rd, b_wr); end
    checks++; if (b_addr !== 32'd0 || b_wdata !== 32'd0 || b_size !== 2'd0) begin errors++; $display("FAIL idle_bus got addr=%h wdata=%h size=%0d exp 0", b_addr, b_wdata, b_size); end
    checks++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %0b%0b exp 00", m0_ready, m1_ready); end
    tick();
  endtask

  task automatic test_both_read();
    do_reset();
    m0_rd = 1; m0_addr = 32'h0000_0100; m1_rd = 1; m1_addr = 32'h0001_0004;
    #1;
    checks++; if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin errors++; $display("FAIL br_c0_ready got %0b%0b exp m0=1 m1=0", m0_ready, m1_ready); end
    checks++; if (b_addr !== 32'h0000_0100 || b_rd !== 1'b1) begin errors++; $display("FAIL br_c0_bus got addr=%h rd=%0b exp 00000100 1", b_addr, b_rd); end
    tick();
    m0_rd = 0; m0_addr = 0; b_rdata = 32'hA5A5_0001;
    #1;
    checks++; if (m1_ready !== 1'b1 || b_addr !== 32'h0001_0004) begin errors++; $display("FAIL br_c1_m1 got ready=%0b addr=%h exp 1 00010004", m1_ready, b_addr); end
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA5A5_0001 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL br_c1_rdata got m0v=%0b d=%h m1v=%0b exp 1 a5a50001 0", m0_rvalid, m0_rdata, m1_rvalid); end
    tick();
    m1_rd = 0; m1_addr = 0; b_rdata = 32'h5A5A_0002;
    #1;
    checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h5A5A_0002 || m0_rvalid !== 1'b0) begin errors++; $display("FAIL br_c2_rdata got m1v=%0b d=%h m0v=%0b exp 1 5a5a0002 0", m1_rvalid, m1_rdata, m0_rvalid); end
    tick();
  endtask

  task automatic test_arbitration_modes();
    do_reset();
    m0_wr = 1; m0_addr = 32'h10; m1_wr = 1; m1_addr = 32'h20;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (m0_ready !== (k % 2 == 0) || m1_ready !== (k % 2 == 1)) begin errors++; $display("FAIL rr_alt_%0d got %0b%0b exp m0=%0b", k, m0_ready, m1_ready, k % 2 == 0); end
      checks++; if (fp_m0_ready !== 1'b1 || fp_m1_ready !== 1'b0) begin errors++; $display("FAIL fixed_prio_%0d got %0b%0b exp m0=1 m1=0", k, fp_m0_ready, fp_m1_ready); end
      tick();
    end
    clear_reqs();
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    m1_wr = 1; m1_addr = 32'h300; m1_lock = 1;
    #1;
    checks++; if (m1_ready !== 1'b1) begin errors++; $display("FAIL lock_first got %0b exp 1", m1_ready); end
    tick();
    m0_wr = 1; m0_addr = 32'h400;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0 || b_addr !== 32'h300) begin errors++; $display("FAIL lock_hold_%0d got m0=%0b m1=%0b addr=%h exp 0 1 300", k, m0_ready, m1_ready, b_addr); end
      tick();
    end
    m1_wr = 0;
    #1;
    checks++; if (m0_ready !== 1'b0 || b_wr !== 1'b0) begin errors++; $display("FAIL lock_idle got m0=%0b wr=%0b exp 0 0", m0_ready, b_wr); end
    tick();
    m1_wr = 1; m1_lock = 0;
    #1;
    checks++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin errors++; $display("FAIL lock_drop got m0=%0b m1=%0b exp 0 1", m0_ready, m1_ready); end
    tick();
    #1;
    checks++; if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin errors++; $display("FAIL lock_release got m0=%0b m1=%0b exp 1 0", m0_ready, m1_ready); end
    tick();
    clear_reqs();
    tick();
  endtask

  task automatic test_illegal_rdwr();
    clear_reqs();
    m0_rd = 1; m0_wr = 1; m0_addr = 32'h2000_0000; m0_wdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (b_wr !== 1'b1 || b_rd !== 1'b0 || m0_ready !== 1'b1) begin errors++; $display("FAIL illegal_fwd got wr=%0b rd=%0b rdy=%0b exp 1 0 1", b_wr, b_rd, m0_ready); end
    checks++; if (b_addr !== 32'h2000_0000 || b_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL illegal_bus got addr=%h wdata=%h exp 20000000 deadbeef", b_addr, b_wdata); end
    tick();
    clear_reqs();
    #1;
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL illegal_no_rvalid got %0b exp 0", m0_rvalid); end
    tick();
  endtask

  task automatic test_reset_pending();
    clear_reqs();
    m1_rd = 1; m1_addr = 32'h500;
    #1;
    checks++; if (m1_ready !== 1'b1) begin errors++; $display("FAIL rp_accept got %0b exp 1", m1_ready); end
    tick();
    clear_reqs();
    rst_n = 1'b0;
    #1;
    checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL rp_in_reset got %0b exp 0", m1_rvalid); end
    #1;
    rst_n = 1'b1;
    model_reset();
    m0_rd = 1; m0_addr = 32'h600; m1_rd = 1; m1_addr = 32'h700;
    #1;
    checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL rp_after_release got %0b exp 0", m1_rvalid); end
    checks++; if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin errors++; $display("FAIL rp_tie_m0 got %0b%0b exp m0=1 m1=0", m0_ready, m1_ready); end
    tick();
    clear_reqs();
    tick();
  endtask

  task automatic test_random();
    int w;
    bit e0, e1, erd, ewr;
    logic [31:0] eaddr, ewdata;
    logic [1:0] esize;
    clear_reqs();
    for (int i = 0; i < 400; i++) begin
      if (!(m0_rd || m0_wr) && $urandom_range(0, 3) != 0) begin
        m0_addr = $urandom; m0_wdata = $urandom; m0_size = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
          0:          {m0_rd, m0_wr} = 2'b11;
          1, 2, 3, 4: {m0_rd, m0_wr} = 2'b10;
          default:    {m0_rd, m0_wr} = 2'b01;
        endcase
      end
      if (!(m1_rd || m1_wr) && $urandom_range(0, 3) != 0) begin
        m1_addr = $urandom; m1_wdata = $urandom; m1_size = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
          0:          {m1_rd, m1_wr} = 2'b11;
          1, 2, 3, 4: {m1_rd, m1_wr} = 2'b10;
          default:    {m1_rd, m1_wr} = 2'b01;
        endcase
      end
      if ($urandom_range(0, 7) == 0) m1_lock = ~m1_lock;
      b_rdata = $urandom;
      #1;
      w = exp_win();
      e0 = (w == 0); e1 = (w == 1);
      erd = 0; ewr = 0; eaddr = 0; ewdata = 0; esize = 0;
      if (e0) begin erd = m0_rd & ~m0_wr; ewr = m0_wr; eaddr = m0_addr; ewdata = m0_wdata; esize = m0_size; end
      if (e1) begin erd = m1_rd & ~m1_wr; ewr = m1_wr; eaddr = m1_addr; ewdata = m1_wdata; esize = m1_size; end
      checks++; if (m0_ready !== e0 || m1_ready !== e1) begin errors++; $display("FAIL rnd_ready_%0d got %0b%0b exp %0b%0b", i, m0_ready, m1_ready, e0, e1); end
      checks++; if (b_rd !== erd || b_wr !== ewr) begin errors++; $display("FAIL rnd_strobe_%0d got rd=%0b wr=%0b exp %0b %0b", i, b_rd, b_wr, erd, ewr); end
      checks++; if (b_addr !== eaddr || b_wdata !== ewdata || b_size !== esize) begin errors++; $display("FAIL rnd_bus_%0d got %h/%h/%0d exp %h/%h/%0d", i, b_addr, b_wdata, b_size, eaddr, ewdata, esize); end
      checks++; if (m0_rvalid !== exp_rvalid(0) || m1_rvalid !== exp_rvalid(1)) begin errors++; $display("FAIL rnd_rvalid_%0d got %0b%0b exp %0b%0b", i, m0_rvalid, m1_rvalid, exp_rvalid(0), exp_rvalid(1)); end
      if (m0_rvalid && exp_rvalid(0)) begin
        checks++; if (m0_rdata !== b_rdata) begin errors++; $display("FAIL rnd_rdata0_%0d got %h exp %h", i, m0_rdata, b_rdata); end
      end
      if (m1_rvalid && exp_rvalid(1)) begin
        checks++; if (m1_rdata !== b_rdata) begin errors++; $display("FAIL rnd_rdata1_%0d got %h exp %h", i, m1_rdata, b_rdata); end
      end
      tick();
      if (w == 0) begin m0_rd = 0; m0_wr = 0; end
      if (w == 1) begin m1_rd = 0; m1_wr = 0; end
    end
    clear_reqs();
    tick();
  endtask

  initial begin
    clear_reqs();
    b_rdata = 0;
    mcyc = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_idle();
    test_both_read();
    test_arbitration_modes();
    test_lock();
    test_illegal_rdwr();
    test_reset_pending();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_arb.md
BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 SHALL have parameter: RR, 1, 1 = round-robin arbitration, 0 = fixed priority with m0 winning.
REQ-002 SHALL have port: clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset_n_i  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports for requester mX, X=0 (instruction fetch) and X=1 (load/store):
- mX_addr_i  in  32  address
- mX_wdata_i  in  32  write data
- mX_size_i  in  2  access size
- mX_rd_i  in  1  read request
- mX_wr_i  in  1  write request
REQ-005 SHALL have ports returned to requester mX:
- mX_ready_o  out  1  request accepted this cycle
- mX_rdata_o  out  32  read data
- mX_rvalid_o  out  1  read data valid
REQ-006 SHALL have port: m1_lock_i  in  1  m1 holds the bus after its next grant (atomic sequences).
REQ-007 SHALL have ports toward the bus mux master port:
- b_addr_o  out  32
- b_wdata_o  out  32
- b_size_o  out  2
- b_rd_o  out  1
- b_wr_o  out  1
- b_rdata_i  in  32  valid one cycle after a read strobe

Function
REQ-008 SHALL treat requester X as requesting when reqX = mX_rd_i | mX_wr_i.
REQ-009 SHALL choose at most one winner per cycle, combinationally, and drive that winner's addr/wdata/size/rd/wr onto b_*; with no winner, b_rd_o=b_wr_o=0 and b_addr_o/b_wdata_o/b_size_o=0.
REQ-010 SHALL assert mX_ready_o in the same cycle requester X wins; a requester holds its request stable until it sees ready; each ready accepts exactly one transfer.
REQ-011 SHALL forward rd=1 and wr=1 together (illegal) as a write only: b_rd_o=0, b_wr_o=1, and no rvalid follows.
REQ-012 SHALL resolve the winner when only one requester requests by granting that requester.
REQ-013 SHALL, when both request and RR=1, grant the requester that did not win most recently (last_r); when RR=0, m0 SHALL always win.
REQ-014 SHALL update last_r to the winner's index on every accepted transfer and hold it otherwise.
REQ-015 SHALL set lock_r on an accepted m1 transfer with m1_lock_i=1.
REQ-016 SHALL clear lock_r on an accepted m1 transfer with m1_lock_i=0, or on any cycle with m1_lock_i=0.
REQ-017 SHALL give m1 exclusive grant while lock_r=1: m0 is never granted and idle cycles are allowed.
REQ-018 SHALL register a pending read on acceptance of a read: pend_r=1 and own_r=winner index.
REQ-019 SHALL clear pend_r one cycle after acceptance unless a new read is accepted in that same cycle.
REQ-020 SHALL support back-to-back reads, one per cycle, from either requester.
REQ-021 SHALL drive mX_rvalid_o = pend_r & (own_r==X) and mX_rdata_o = b_rdata_i; rdata SHALL be unqualified when rvalid=0.
REQ-022 SHALL therefore deliver read data exactly 1 cycle after the ready cycle; writes SHALL complete in the ready cycle.
REQ-023 SHALL apply the same arbitration to a write accepted in the cycle a prior read's data returns; the returning data SHALL still go to own_r.

Reset
REQ-024 SHALL, on reset_n_i=0, asynchronously clear state to: last_r=1 (m0 wins first tie), lock_r=0, pend_r=0, own_r=0.
REQ-025 SHALL hold all outputs during reset at: mX_rvalid_o=0, mX_ready_o=0, b_rd_o=0, b_wr_o=0.
REQ-026 SHALL discard a read pending when reset asserts: no rvalid after reset release.

Verification
REQ-027 SHALL pass: after reset, both read at once (m0 addr 0x00000100, m1 addr 0x00010004) -> m0 ready cycle 0, m1 ready cycle 1; m0_rvalid cycle 1, m1_rvalid cycle 2 with the matching b_rdata_i.
REQ-028 SHALL pass: both requesting continuously with RR=1 -> grants alternate m0,m1,m0,m1; with RR=0 -> m0 every cycle and m1 never granted.
REQ-029 SHALL pass: m1 write with m1_lock_i=1, then m0 and m1 both request for 3 cycles with lock held -> m1 granted each cycle; drop lock -> m0 granted next.
REQ-030 SHALL pass: m0 rd=1 and wr=1 together, addr 0x20000000 -> b_wr_o=1, b_rd_o=0, m0_ready=1, no m0_rvalid.
REQ-031 SHALL pass: m1 read accepted, reset_n_i pulsed low before the next edge -> m1_rvalid stays 0 and last_r=1 after release.
REQ-032 SHALL pass: idle bus -> b_rd_o=b_wr_o=0, b_addr_o=0, both ready=0.
